// File: rtl/eic_sense_core.sv
// External interrupt controller core for the microAptiv EIC interface: sense logic, flags, mask, arbiter.
// Define EIC_SENSE_SYNC_EN to put a 2-flop synchroniser in front of every signal bit.
module eic_sense_core #(
  parameter int CHANNELS = 10,
  parameter int ADDR_W   = 5
) (
  input  logic                CLK,
  input  logic                RESETn,
  input  logic [CHANNELS-1:0] signal,
  input  logic [ADDR_W-1:0]   read_addr,
  output logic [31:0]         read_data,
  input  logic [ADDR_W-1:0]   write_addr,
  input  logic [31:0]         write_data,
  input  logic                write_enable,
  output logic [17:1]         EIC_Offset,
  output logic [3:0]          EIC_ShadowSet,
  output logic [7:0]          EIC_Interrupt,
  output logic [5:0]          EIC_Vector,
  output logic                EIC_Present
);

  localparam logic [ADDR_W-1:0] A_EICR   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_EIMR   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_EIFR   = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_EIFRS  = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_EIFRC  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_EISMSL = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_EISMSH = ADDR_W'(6);
  localparam logic [ADDR_W-1:0] A_EIVEC  = ADDR_W'(7);

  logic [CHANNELS-1:0]   sig_in;
  logic [CHANNELS-1:0]   sample_reg;
  logic [CHANNELS-1:0]   hist_reg;
  logic                  eicr_reg;
  logic [CHANNELS-1:0]   eimr_reg;
  logic [CHANNELS-1:0]   eifr_reg;
  logic [CHANNELS-1:0]   eifr_next;
  logic [2*CHANNELS-1:0] sense_reg;
  logic [2*CHANNELS-1:0] sense_next;
  logic [5:0]            vec_reg;
  logic                  irq_reg;
  logic [31:0]           read_data_reg;
  logic [CHANNELS-1:0]   req;
  logic [5:0]            win_vec;
  logic [31:0]           rd_mux;
  logic [63:0]           sense_full;
  logic                  wr_eicr;
  logic                  wr_eimr;
  logic                  wr_set;
  logic                  wr_clr;
  logic                  unused_wdata;

`ifdef EIC_SENSE_SYNC_EN
  logic [CHANNELS-1:0] sync1_reg;
  logic [CHANNELS-1:0] sync2_reg;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= signal;
      sync2_reg <= sync1_reg;
    end
  end

  assign sig_in = sync2_reg;
`else
  assign sig_in = signal;
`endif

  assign wr_eicr = write_enable && (write_addr == A_EICR);
  assign wr_eimr = write_enable && (write_addr == A_EIMR);
  assign wr_set  = write_enable && (write_addr == A_EIFRS);
  assign wr_clr  = write_enable && (write_addr == A_EIFRC);

  // Upper data bits beyond the implemented channels are intentionally ignored.
  assign unused_wdata = ^write_data;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      localparam int SENSE_ADDR = (gi < 16) ? 5 : 6;
      localparam int SENSE_BIT  = (gi % 16) * 2;
      logic [1:0] mode;
      logic       rise;
      logic       fall;
      logic       evt;

      assign mode = sense_reg[2*gi +: 2];
      assign rise = sample_reg[gi] & ~hist_reg[gi];
      assign fall = ~sample_reg[gi] & hist_reg[gi];

      always_comb begin
        evt = 1'b0;
        case (mode)
          2'b01:   evt = rise;
          2'b10:   evt = fall;
          2'b11:   evt = rise | fall;
          default: evt = 1'b0;
        endcase
      end

      // Edge flags are sticky; an event in the same cycle as a clear keeps the flag set.
      assign eifr_next[gi] = (mode == 2'b00) ? sample_reg[gi]
                           : (evt | (wr_set & write_data[gi]) |
                              (eifr_reg[gi] & ~(wr_clr & write_data[gi])));

      assign sense_next[2*gi +: 2] =
        (write_enable && (write_addr == ADDR_W'(SENSE_ADDR))) ? write_data[SENSE_BIT +: 2] : mode;
    end
  endgenerate

  assign req = eifr_reg & eimr_reg & {CHANNELS{eicr_reg}};

  // Later (higher) indices overwrite earlier ones, giving fixed highest-index priority.
  always_comb begin
    win_vec = 6'd0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (req[i]) win_vec = 6'(i + 1);
    end
  end

  assign sense_full = 64'(sense_reg);

  always_comb begin
    rd_mux = 32'd0;
    case (read_addr)
      A_EICR:   rd_mux = {31'd0, eicr_reg};
      A_EIMR:   rd_mux = 32'(eimr_reg);
      A_EIFR:   rd_mux = 32'(eifr_reg);
      A_EISMSL: rd_mux = sense_full[31:0];
      A_EISMSH: rd_mux = sense_full[63:32];
      A_EIVEC:  rd_mux = {26'd0, vec_reg};
      default:  rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      sample_reg    <= '0;
      hist_reg      <= '0;
      eicr_reg      <= 1'b0;
      eimr_reg      <= '0;
      eifr_reg      <= '0;
      sense_reg     <= '0;
      vec_reg       <= 6'd0;
      irq_reg       <= 1'b0;
      read_data_reg <= 32'd0;
    end else begin
      sample_reg <= sig_in;
      hist_reg   <= sample_reg;
      if (wr_eicr) eicr_reg <= write_data[0];
      if (wr_eimr) eimr_reg <= write_data[CHANNELS-1:0];
      eifr_reg      <= eifr_next;
      sense_reg     <= sense_next;
      vec_reg       <= win_vec;
      irq_reg       <= |req;
      read_data_reg <= rd_mux;
    end
  end

  assign read_data     = read_data_reg;
  assign EIC_Vector    = vec_reg;
  assign EIC_Interrupt = {7'd0, irq_reg};
  assign EIC_Offset    = 17'd0;
  assign EIC_ShadowSet = 4'd0;
  assign EIC_Present   = 1'b1;

endmodule

// File: tb/tb_eic_sense_core.sv
// Scoreboard bench for eic_sense_core: stimulus queues expected read/vector values, a monitor checks each read response.
module tb_eic_sense_core;

`ifdef EIC_SENSE_SYNC_EN
  localparam int SE = 2;
`else
  localparam int SE = 0;
`endif
  localparam int ST = 4 + SE;

  typedef struct {
    logic [31:0] data;
    logic [5:0]  vec;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [9:0]  sig = '0;
  logic [4:0]  read_addr = '0;
  logic [31:0] read_data;
  logic [4:0]  write_addr = '0;
  logic [31:0] write_data = '0;
  logic        write_enable = 1'b0;
  logic [17:1] eic_offset;
  logic [3:0]  eic_shadow;
  logic [7:0]  eic_int;
  logic [5:0]  eic_vec;
  logic        eic_present;

  logic rd_req = 1'b0;
  logic rd_pend = 1'b0;
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fails = 0;

  eic_sense_core #(.CHANNELS(10), .ADDR_W(5)) dut (
    .CLK(clk), .RESETn(resetn), .signal(sig),
    .read_addr(read_addr), .read_data(read_data),
    .write_addr(write_addr), .write_data(write_data), .write_enable(write_enable),
    .EIC_Offset(eic_offset), .EIC_ShadowSet(eic_shadow), .EIC_Interrupt(eic_int),
    .EIC_Vector(eic_vec), .EIC_Present(eic_present)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string what, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s %s: got %0h expected %0h", nm, what, act, req);
    end
  endtask

  // Monitor: a read issued before a rising edge produces its response on the following falling edge.
  always @(posedge clk) rd_pend <= rd_req;

  always @(negedge clk) begin
    exp_t e;
    if (rd_pend) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", "queue_size", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk(e.name, "read_data", read_data, e.data);
        chk(e.name, "EIC_Vector", 32'(eic_vec), 32'(e.vec));
        chk(e.name, "EIC_Interrupt", 32'(eic_int), (e.vec != 6'd0) ? 32'd1 : 32'd0);
        chk(e.name, "EIC_Present", 32'(eic_present), 32'd1);
        chk(e.name, "EIC_Offset", 32'(eic_offset), 32'd0);
        chk(e.name, "EIC_ShadowSet", 32'(eic_shadow), 32'd0);
        $display("read %-22s data=%08h vec=%0d int=%0d", e.name, read_data, eic_vec, eic_int);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    write_addr = a; write_data = d; write_enable = 1'b1;
    @(negedge clk);
    write_enable = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] d, input logic [5:0] v, input string nm);
    exp_t e;
    e.data = d; e.vec = v; e.name = nm;
    sb.push_back(e);
    read_addr = a; rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic wrrd(input logic [4:0] wa, input logic [31:0] wd, input logic [4:0] ra,
                      input logic [31:0] d, input logic [5:0] v, input string nm);
    exp_t e;
    e.data = d; e.vec = v; e.name = nm;
    sb.push_back(e);
    write_addr = wa; write_data = wd; write_enable = 1'b1;
    read_addr = ra; rd_req = 1'b1;
    @(negedge clk);
    write_enable = 1'b0; rd_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tick(3);
    resetn = 1'b1;

    // Reset state of every register, including unmapped addresses
    for (int a = 0; a < 8; a++) rd(5'(a), 32'd0, 6'd0, "t1_reset");
    rd(5'd8, 32'd0, 6'd0, "t1_unmapped8");
    rd(5'd31, 32'd0, 6'd0, "t1_unmapped31");

    // Rising edge on ch0, exact latency to the vector
    wr(5'd0, 32'h1);
    wr(5'd1, 32'h3FF);
    wr(5'd5, 32'h1);
    sig[0] = 1'b1;
    for (int k = 1; k <= 4 + SE; k++)
      rd(5'd7, (k >= 4 + SE) ? 32'd1 : 32'd0, (k >= 3 + SE) ? 6'd1 : 6'd0, "t2_latency");
    sig[0] = 1'b0;
    tick(ST);
    rd(5'd2, 32'h1, 6'd1, "t2_hold_flag");
    rd(5'd7, 32'h1, 6'd1, "t2_hold_vec");
    wr(5'd4, 32'h1);
    rd(5'd2, 32'h0, 6'd0, "t2_clear");

    // Priority: ch5 rising, ch9 level
    wr(5'd5, 32'h401);
    sig[5] = 1'b1;
    tick(ST);
    rd(5'd7, 32'd6, 6'd6, "t3_ch5");
    sig[9] = 1'b1;
    tick(ST);
    rd(5'd7, 32'd10, 6'd10, "t3_ch9");
    rd(5'd2, 32'h220, 6'd10, "t3_flags");
    sig[9] = 1'b0;
    tick(ST);
    rd(5'd7, 32'd6, 6'd6, "t3_ch9_release");
    rd(5'd2, 32'h020, 6'd6, "t3_flags2");

    // Mask and global enable with ch3 pending; read during write returns the old value
    wr(5'd4, 32'h20);
    wr(5'd5, 32'h441);
    sig[3] = 1'b1;
    tick(ST);
    rd(5'd7, 32'd4, 6'd4, "t4_ch3");
    wrrd(5'd1, 32'h3F7, 5'd1, 32'h3FF, 6'd4, "t4_rd_during_wr");
    tick(1);
    rd(5'd7, 32'd0, 6'd0, "t4_masked");
    rd(5'd2, 32'h008, 6'd0, "t4_flag_kept");
    rd(5'd1, 32'h3F7, 6'd0, "t4_eimr");
    wr(5'd1, 32'h3FF);
    tick(1);
    rd(5'd7, 32'd4, 6'd4, "t4_unmask");
    wr(5'd0, 32'h0);
    tick(1);
    rd(5'd7, 32'd0, 6'd0, "t4_disable");
    rd(5'd2, 32'h008, 6'd0, "t4_flag_kept2");
    wr(5'd0, 32'h1);
    tick(1);
    rd(5'd7, 32'd4, 6'd4, "t4_enable");

    // Clear and rising edge on ch2 in the same cycle: set wins
    wr(5'd5, 32'h451);
    sig[2] = 1'b1;
    tick(1 + SE);
    wr(5'd4, 32'h4);
    tick(1);
    rd(5'd2, 32'h00C, 6'd4, "t5_set_wins");
    wr(5'd4, 32'h4);
    rd(5'd2, 32'h008, 6'd4, "t5_clear_later");

    // Flag set/clear writes on level vs edge channels
    wr(5'd3, 32'h200);
    rd(5'd2, 32'h008, 6'd4, "t6_level_set_ignored");
    wr(5'd3, 32'h1);
    rd(5'd2, 32'h009, 6'd4, "t6_edge_set");
    sig[9] = 1'b1;
    tick(ST);
    wr(5'd4, 32'h200);
    rd(5'd2, 32'h209, 6'd10, "t6_level_clr_ignored");
    sig[9] = 1'b0;
    tick(ST);

    // Falling-edge ch1, any-edge ch4
    wr(5'd5, 32'h759);
    wr(5'd4, 32'h9);
    sig[1] = 1'b1;
    tick(ST);
    rd(5'd2, 32'h000, 6'd0, "t7_fall_no_rise");
    sig[1] = 1'b0;
    tick(ST);
    rd(5'd2, 32'h002, 6'd2, "t7_fall");
    sig[4] = 1'b1;
    tick(ST);
    rd(5'd2, 32'h012, 6'd5, "t7_any_rise");
    wr(5'd4, 32'h10);
    sig[4] = 1'b0;
    tick(ST);
    rd(5'd2, 32'h012, 6'd5, "t7_any_fall");

    // Bits for channels beyond CHANNELS and write-only addresses
    wr(5'd1, 32'hFFFFFFFF);
    rd(5'd1, 32'h3FF, 6'd5, "t8_eimr_range");
    wr(5'd6, 32'hFFFFFFFF);
    rd(5'd6, 32'h0, 6'd5, "t8_eismsh");
    wr(5'd5, 32'hFFF00759);
    rd(5'd5, 32'h759, 6'd5, "t8_eismsl");
    wr(5'd3, 32'hFFFFFC00);
    rd(5'd2, 32'h012, 6'd5, "t8_eifrs_range");
    wr(5'd0, 32'hFFFFFFFF);
    rd(5'd0, 32'h1, 6'd5, "t8_eicr");
    rd(5'd3, 32'h0, 6'd5, "t8_eifrs_read");
    rd(5'd4, 32'h0, 6'd5, "t8_eifrc_read");

    // Reset mid-operation
    resetn = 1'b0;
    rd(5'd2, 32'h0, 6'd0, "t9_in_reset");
    tick(2);
    resetn = 1'b1;
    rd(5'd1, 32'h0, 6'd0, "t9_eimr");
    rd(5'd5, 32'h0, 6'd0, "t9_eismsl");
    rd(5'd0, 32'h0, 6'd0, "t9_eicr");
    tick(ST);
    rd(5'd2, 32'h02C, 6'd0, "t9_level_follow");

    sig = '0;
    tick(3);
    chk("end", "pending_expectations", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
